// File: rtl/id_ex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_register
// Description : Decode -> Execute pipeline register for the 5-stage RISC-V
//               core. Holds operands, immediate, PC values, register
//               addresses, ALU/memory/branch controls and the EX-stage mux
//               selects. Supports stall (hold), flush (bubble), a same-cycle
//               write-back bypass into both captured operands, and detection
//               and neutralisation of mux select codes that have no input.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALUOP_WIDTH    = 5
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      STALL,
  input  logic                      FLUSH,

  input  logic [DATA_WIDTH-1:0]     PC_IN,
  input  logic [DATA_WIDTH-1:0]     PC4_IN,
  input  logic [DATA_WIDTH-1:0]     DATA1_IN,
  input  logic [DATA_WIDTH-1:0]     DATA2_IN,
  input  logic [DATA_WIDTH-1:0]     IMM_IN,
  input  logic [REG_ADDR_WIDTH-1:0] RS1_IN,
  input  logic [REG_ADDR_WIDTH-1:0] RS2_IN,
  input  logic [REG_ADDR_WIDTH-1:0] RD_IN,
  input  logic                      MUX1_SEL_IN,
  input  logic [2:0]                MUX2_SEL_IN,
  input  logic                      MUX3_SEL_IN,
  input  logic [1:0]                MUX4_SEL_IN,
  input  logic                      MUX5_SEL_IN,
  input  logic [ALUOP_WIDTH-1:0]    ALUOP_IN,
  input  logic                      REG_WRITE_IN,
  input  logic                      MEM_READ_IN,
  input  logic                      MEM_WRITE_IN,
  input  logic [2:0]                FUNCT3_IN,
  input  logic [3:0]                BRANCH_JUMP_IN,
  input  logic                      VALID_IN,

  input  logic                      WB_WRITE_EN,
  input  logic [REG_ADDR_WIDTH-1:0] WB_RD,
  input  logic [DATA_WIDTH-1:0]     WB_DATA,

  output logic [DATA_WIDTH-1:0]     PC_OUT,
  output logic [DATA_WIDTH-1:0]     PC4_OUT,
  output logic [DATA_WIDTH-1:0]     DATA1_OUT,
  output logic [DATA_WIDTH-1:0]     DATA2_OUT,
  output logic [DATA_WIDTH-1:0]     IMM_OUT,
  output logic [REG_ADDR_WIDTH-1:0] RS1_OUT,
  output logic [REG_ADDR_WIDTH-1:0] RS2_OUT,
  output logic [REG_ADDR_WIDTH-1:0] RD_OUT,
  output logic                      MUX1_SEL_OUT,
  output logic [2:0]                MUX2_SEL_OUT,
  output logic                      MUX3_SEL_OUT,
  output logic [1:0]                MUX4_SEL_OUT,
  output logic                      MUX5_SEL_OUT,
  output logic [ALUOP_WIDTH-1:0]    ALUOP_OUT,
  output logic                      REG_WRITE_OUT,
  output logic                      MEM_READ_OUT,
  output logic                      MEM_WRITE_OUT,
  output logic [2:0]                FUNCT3_OUT,
  output logic [3:0]                BRANCH_JUMP_OUT,
  output logic                      VALID_OUT,
  output logic                      ILLEGAL_SEL_OUT
);

  // mux2 has five inputs (codes 0..4); mux4 has three (codes 0..2)
  localparam logic [2:0] C_MUX2_LAST    = 3'd4;
  localparam logic [1:0] C_MUX4_ILLEGAL = 2'd3;
  localparam logic [REG_ADDR_WIDTH-1:0] C_X0 = '0;

  // Everything the slot carries; an all-zero value is both the reset state
  // and a bubble (no write, no memory access, no branch, all muxes input 1).
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc4;
    logic [DATA_WIDTH-1:0]     data1;
    logic [DATA_WIDTH-1:0]     data2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      mux1_sel;
    logic [2:0]                mux2_sel;
    logic                      mux3_sel;
    logic [1:0]                mux4_sel;
    logic                      mux5_sel;
    logic [ALUOP_WIDTH-1:0]    aluop;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic [2:0]                funct3;
    logic [3:0]                branch_jump;
    logic                      valid;
    logic                      illegal_sel;
  } payload_t;

  payload_t payload_d;
  payload_t payload_q;

  logic w_bypass1;
  logic w_bypass2;
  logic w_mux2_bad;
  logic w_mux4_bad;
  logic w_illegal;

  // Classify the incoming selects and decide whether write-back data must
  // replace either register-file operand (x0 is hardwired, never bypassed).
  always_comb begin
    w_mux2_bad = (MUX2_SEL_IN > C_MUX2_LAST);
    w_mux4_bad = (MUX4_SEL_IN == C_MUX4_ILLEGAL);
    w_illegal  = VALID_IN & (w_mux2_bad | w_mux4_bad);
    w_bypass1  = WB_WRITE_EN & (WB_RD != C_X0) & (WB_RD == RS1_IN);
    w_bypass2  = WB_WRITE_EN & (WB_RD != C_X0) & (WB_RD == RS2_IN);
  end

  // Assemble the value captured on a normal (non-stalled, non-flushed) edge.
  // Undefined selects are zeroed whether or not the slot is valid; the side
  // effects are only suppressed (and the flag raised) for a real instruction.
  always_comb begin
    payload_d             = '0;
    payload_d.pc          = PC_IN;
    payload_d.pc4         = PC4_IN;
    payload_d.data1       = w_bypass1 ? WB_DATA : DATA1_IN;
    payload_d.data2       = w_bypass2 ? WB_DATA : DATA2_IN;
    payload_d.imm         = IMM_IN;
    payload_d.rs1         = RS1_IN;
    payload_d.rs2         = RS2_IN;
    payload_d.rd          = RD_IN;
    payload_d.mux1_sel    = MUX1_SEL_IN;
    payload_d.mux2_sel    = w_mux2_bad ? 3'd0 : MUX2_SEL_IN;
    payload_d.mux3_sel    = MUX3_SEL_IN;
    payload_d.mux4_sel    = w_mux4_bad ? 2'd0 : MUX4_SEL_IN;
    payload_d.mux5_sel    = MUX5_SEL_IN;
    payload_d.aluop       = ALUOP_IN;
    payload_d.reg_write   = REG_WRITE_IN   & ~w_illegal;
    payload_d.mem_read    = MEM_READ_IN    & ~w_illegal;
    payload_d.mem_write   = MEM_WRITE_IN   & ~w_illegal;
    payload_d.funct3      = FUNCT3_IN;
    payload_d.branch_jump = w_illegal ? 4'd0 : BRANCH_JUMP_IN;
    payload_d.valid       = VALID_IN;
    payload_d.illegal_sel = w_illegal;
  end

  // Slot update with priority reset > flush > stall > capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      payload_q <= '0;
    end else if (FLUSH) begin
      payload_q <= '0;
    end else if (!STALL) begin
      payload_q <= payload_d;
    end
  end

  assign PC_OUT          = payload_q.pc;
  assign PC4_OUT         = payload_q.pc4;
  assign DATA1_OUT       = payload_q.data1;
  assign DATA2_OUT       = payload_q.data2;
  assign IMM_OUT         = payload_q.imm;
  assign RS1_OUT         = payload_q.rs1;
  assign RS2_OUT         = payload_q.rs2;
  assign RD_OUT          = payload_q.rd;
  assign MUX1_SEL_OUT    = payload_q.mux1_sel;
  assign MUX2_SEL_OUT    = payload_q.mux2_sel;
  assign MUX3_SEL_OUT    = payload_q.mux3_sel;
  assign MUX4_SEL_OUT    = payload_q.mux4_sel;
  assign MUX5_SEL_OUT    = payload_q.mux5_sel;
  assign ALUOP_OUT       = payload_q.aluop;
  assign REG_WRITE_OUT   = payload_q.reg_write;
  assign MEM_READ_OUT    = payload_q.mem_read;
  assign MEM_WRITE_OUT   = payload_q.mem_write;
  assign FUNCT3_OUT      = payload_q.funct3;
  assign BRANCH_JUMP_OUT = payload_q.branch_jump;
  assign VALID_OUT       = payload_q.valid;
  assign ILLEGAL_SEL_OUT = payload_q.illegal_sel;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipeline_register
// Description : Scoreboard bench for id_ex_pipeline_register. Stimulus pushes
//               the expected register contents into a queue; a monitor pops
//               and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        m1;
    logic [2:0]  m2;
    logic        m3;
    logic [1:0]  m4;
    logic        m5;
    logic [4:0]  aluop;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [3:0]  bj;
    logic        valid;
    logic        wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
  } in_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        m1;
    logic [2:0]  m2;
    logic        m3;
    logic [1:0]  m4;
    logic        m5;
    logic [4:0]  aluop;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [3:0]  bj;
    logic        valid;
    logic        ill;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  cur_in = '0;
  out_t exp_state = '0;
  out_t exp_q[$];
  string nm_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] PC_OUT, PC4_OUT, DATA1_OUT, DATA2_OUT, IMM_OUT;
  logic [4:0]  RS1_OUT, RS2_OUT, RD_OUT, ALUOP_OUT;
  logic        MUX1_SEL_OUT, MUX3_SEL_OUT, MUX5_SEL_OUT;
  logic [2:0]  MUX2_SEL_OUT, FUNCT3_OUT;
  logic [1:0]  MUX4_SEL_OUT;
  logic        REG_WRITE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, VALID_OUT, ILLEGAL_SEL_OUT;
  logic [3:0]  BRANCH_JUMP_OUT;

  id_ex_pipeline_register #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALUOP_WIDTH(5)
  ) dut (
    .CLK(clk), .RESET(cur_in.rst), .STALL(cur_in.stall), .FLUSH(cur_in.flush),
    .PC_IN(cur_in.pc), .PC4_IN(cur_in.pc4), .DATA1_IN(cur_in.d1), .DATA2_IN(cur_in.d2),
    .IMM_IN(cur_in.imm), .RS1_IN(cur_in.rs1), .RS2_IN(cur_in.rs2), .RD_IN(cur_in.rd),
    .MUX1_SEL_IN(cur_in.m1), .MUX2_SEL_IN(cur_in.m2), .MUX3_SEL_IN(cur_in.m3),
    .MUX4_SEL_IN(cur_in.m4), .MUX5_SEL_IN(cur_in.m5), .ALUOP_IN(cur_in.aluop),
    .REG_WRITE_IN(cur_in.rw), .MEM_READ_IN(cur_in.mr), .MEM_WRITE_IN(cur_in.mw),
    .FUNCT3_IN(cur_in.f3), .BRANCH_JUMP_IN(cur_in.bj), .VALID_IN(cur_in.valid),
    .WB_WRITE_EN(cur_in.wbe), .WB_RD(cur_in.wbrd), .WB_DATA(cur_in.wbdata),
    .PC_OUT(PC_OUT), .PC4_OUT(PC4_OUT), .DATA1_OUT(DATA1_OUT), .DATA2_OUT(DATA2_OUT),
    .IMM_OUT(IMM_OUT), .RS1_OUT(RS1_OUT), .RS2_OUT(RS2_OUT), .RD_OUT(RD_OUT),
    .MUX1_SEL_OUT(MUX1_SEL_OUT), .MUX2_SEL_OUT(MUX2_SEL_OUT), .MUX3_SEL_OUT(MUX3_SEL_OUT),
    .MUX4_SEL_OUT(MUX4_SEL_OUT), .MUX5_SEL_OUT(MUX5_SEL_OUT), .ALUOP_OUT(ALUOP_OUT),
    .REG_WRITE_OUT(REG_WRITE_OUT), .MEM_READ_OUT(MEM_READ_OUT), .MEM_WRITE_OUT(MEM_WRITE_OUT),
    .FUNCT3_OUT(FUNCT3_OUT), .BRANCH_JUMP_OUT(BRANCH_JUMP_OUT), .VALID_OUT(VALID_OUT),
    .ILLEGAL_SEL_OUT(ILLEGAL_SEL_OUT)
  );

  // Reference: what the slot should hold after an edge, from the stated rules.
  function automatic out_t model(input out_t prev, input in_t i);
    out_t n;
    bit   sel2_undef;
    bit   sel4_undef;
    bit   flagged;
    if (i.rst || i.flush) return '0;
    if (i.stall) return prev;
    sel2_undef = (i.m2 >= 3'd5);
    sel4_undef = (i.m4 == 2'd3);
    flagged    = i.valid && (sel2_undef || sel4_undef);
    n.pc    = i.pc;
    n.pc4   = i.pc4;
    n.d1    = (i.wbe && i.wbrd != 0 && i.wbrd == i.rs1) ? i.wbdata : i.d1;
    n.d2    = (i.wbe && i.wbrd != 0 && i.wbrd == i.rs2) ? i.wbdata : i.d2;
    n.imm   = i.imm;
    n.rs1   = i.rs1;
    n.rs2   = i.rs2;
    n.rd    = i.rd;
    n.m1    = i.m1;
    n.m2    = sel2_undef ? 3'd0 : i.m2;
    n.m3    = i.m3;
    n.m4    = sel4_undef ? 2'd0 : i.m4;
    n.m5    = i.m5;
    n.aluop = i.aluop;
    n.rw    = flagged ? 1'b0 : i.rw;
    n.mr    = flagged ? 1'b0 : i.mr;
    n.mw    = flagged ? 1'b0 : i.mw;
    n.f3    = i.f3;
    n.bj    = flagged ? 4'd0 : i.bj;
    n.valid = i.valid;
    n.ill   = flagged;
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.rst    = 1'b0;
    v.flush  = 1'b0;
    v.stall  = 1'b0;
    v.pc     = $urandom;
    v.pc4    = $urandom;
    v.d1     = $urandom;
    v.d2     = $urandom;
    v.imm    = $urandom;
    v.rs1    = 5'($urandom_range(0, 31));
    v.rs2    = 5'($urandom_range(0, 31));
    v.rd     = 5'($urandom_range(0, 31));
    v.m1     = 1'($urandom_range(0, 1));
    v.m2     = 3'($urandom_range(0, 7));
    v.m3     = 1'($urandom_range(0, 1));
    v.m4     = 2'($urandom_range(0, 3));
    v.m5     = 1'($urandom_range(0, 1));
    v.aluop  = 5'($urandom_range(0, 31));
    v.rw     = 1'($urandom_range(0, 1));
    v.mr     = 1'($urandom_range(0, 1));
    v.mw     = 1'($urandom_range(0, 1));
    v.f3     = 3'($urandom_range(0, 7));
    v.bj     = 4'($urandom_range(0, 15));
    v.valid  = ($urandom_range(0, 3) != 0);
    v.wbe    = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       v.wbrd = v.rs1;
      1:       v.wbrd = v.rs2;
      default: v.wbrd = 5'($urandom_range(0, 31));
    endcase
    v.wbdata = $urandom;
    return v;
  endfunction

  // Legal selects and no bypass, so a captured slot is fully predictable.
  function automatic in_t legal_in();
    in_t v;
    v = rand_in();
    v.m2  = 3'($urandom_range(0, 4));
    v.m4  = 2'($urandom_range(0, 2));
    v.wbe = 1'b0;
    return v;
  endfunction

  task automatic step(input in_t v, input string name);
    cur_in    = v;
    exp_state = model(exp_state, v);
    exp_q.push_back(exp_state);
    nm_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor: the slot presents new contents after every edge.
  initial begin
    out_t  act;
    out_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        act = {PC_OUT, PC4_OUT, DATA1_OUT, DATA2_OUT, IMM_OUT, RS1_OUT, RS2_OUT, RD_OUT,
               MUX1_SEL_OUT, MUX2_SEL_OUT, MUX3_SEL_OUT, MUX4_SEL_OUT, MUX5_SEL_OUT,
               ALUOP_OUT, REG_WRITE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, FUNCT3_OUT,
               BRANCH_JUMP_OUT, VALID_OUT, ILLEGAL_SEL_OUT};
        tests++;
        if (act !== e) begin
          fails++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_t v;
    in_t held;
    @(negedge clk);

    // reset with every input high
    v = '1;
    step(v, "reset_ones_0");
    step(v, "reset_ones_1");

    // first capture after reset release
    v = '0;
    v.pc = 32'h0000_0040; v.d1 = 32'h1234_5678; v.m2 = 3'd3; v.rw = 1'b1; v.valid = 1'b1;
    step(v, "first_capture");

    // capture then stall three cycles with changing inputs
    step(legal_in(), "capture_before_stall");
    for (int k = 0; k < 3; k++) begin
      v = rand_in(); v.stall = 1'b1;
      step(v, "stall_hold");
    end
    step(legal_in(), "stall_release");

    // stall and flush together on a slot that writes and stores
    v = legal_in(); v.rw = 1'b1; v.mw = 1'b1; v.valid = 1'b1;
    step(v, "pre_flush_capture");
    v = rand_in(); v.stall = 1'b1; v.flush = 1'b1;
    step(v, "stall_flush");

    // write-back bypass on both ports, then x0 never bypassed
    v = legal_in();
    v.rs1 = 5'd5; v.rs2 = 5'd5; v.wbe = 1'b1; v.wbrd = 5'd5;
    v.wbdata = 32'hDEAD_BEEF; v.d1 = 32'h1111_1111; v.d2 = 32'h1111_1111;
    step(v, "bypass_both");
    v.wbrd = 5'd0; v.rs1 = 5'd0;
    step(v, "bypass_x0");

    // undefined selects: flagged when valid, only neutralised when not
    v = legal_in(); v.valid = 1'b1; v.m2 = 3'd6; v.mw = 1'b1; v.rw = 1'b1; v.bj = 4'hF;
    step(v, "illegal_mux2_valid");
    v = legal_in(); v.valid = 1'b0; v.m4 = 2'd3;
    step(v, "illegal_mux4_invalid");
    v = legal_in(); v.valid = 1'b1; v.m2 = 3'd7; v.m4 = 2'd3;
    step(v, "illegal_both_valid");

    // reset pulse in the middle of a stall, then immediate capture
    v = legal_in(); v.valid = 1'b1;
    step(v, "capture_before_reset");
    held = v; held.stall = 1'b1;
    step(held, "stall_before_reset");
    held.rst = 1'b1;
    step(held, "reset_in_stall");
    v = legal_in(); v.valid = 1'b1;
    step(v, "capture_after_reset");

    // randomized traffic with occasional control events
    for (int k = 0; k < 300; k++) begin
      v = rand_in();
      v.rst   = ($urandom_range(0, 39) == 0);
      v.flush = ($urandom_range(0, 11) == 0);
      v.stall = ($urandom_range(0, 4) == 0);
      step(v, "random");
    end

    v = legal_in();
    step(v, "final_capture");
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
